// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared types and width helpers for the product accumulator.
// Holds the group FSM state type and the term-count width helper used by the top.

package product_acc_pkg;

  // Group FSM states.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Default geometry of the accumulator stage.
  localparam int DEF_MUL_WIDTH = 16;
  localparam int DEF_DOT_LEN   = 4;
  localparam int DEF_ACC_WIDTH = 40;

  // Bits needed to hold a term count in the range 0..dot_len inclusive.
  function automatic int count_width(input int dot_len);
    return $clog2(dot_len + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_adder.sv
// acc_adder: combinational accumulate step for the product accumulator.
// Sign-extends one product term, adds it to the running sum and flags signed
// overflow of that add. With PRODUCT_ACC_SATURATE_EN defined, an overflowing
// sum clamps to the signed max/min of ACC_WIDTH; otherwise it wraps.

module acc_adder #(
  parameter int MUL_WIDTH = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [2*MUL_WIDTH-1:0] term,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic                   overflow
);

  localparam int PW = 2 * MUL_WIDTH;
  // One guard bit above the accumulator exposes the true sign of the sum.
  localparam int XW = ACC_WIDTH + 1;

`ifdef PRODUCT_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  logic [XW-1:0] acc_x;
  logic [XW-1:0] term_x;
  logic [XW-1:0] sum_x;

  // Widen both operands, add, and detect overflow as guard bit != result sign.
  always_comb begin
    acc_x    = {acc[ACC_WIDTH-1], acc};
    term_x   = {{(XW-PW){term[PW-1]}}, term};
    sum_x    = acc_x + term_x;
    overflow = sum_x[XW-1] ^ sum_x[XW-2];
`ifdef PRODUCT_ACC_SATURATE_EN
    // The guard bit carries the sign of the true sum, picking the clamp side.
    if (overflow) begin
      sum = sum_x[XW-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_x[ACC_WIDTH-1:0];
    end
`else
    sum = sum_x[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of up to DOT_LEN signed products into one
// signed dot-product result, presented with its term count and a sticky
// overflow flag over a valid/ready handshake.
// Optional feature macro: PRODUCT_ACC_SATURATE_EN (clamp instead of wrap,
// implemented inside acc_adder).
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | accepting terms; closes the group on DOT_LEN terms or src_last
// HOLD  | result presented on dest_*; waits for dest_ready, no accepts

module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int MUL_WIDTH = DEF_MUL_WIDTH,
  parameter int DOT_LEN   = DEF_DOT_LEN,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*MUL_WIDTH-1:0]       product,
  input  logic                         src_valid,
  input  logic                         src_last,
  output logic                         src_ready,
  output logic [ACC_WIDTH-1:0]         result,
  output logic [$clog2(DOT_LEN+1)-1:0] result_count,
  output logic                         overflow,
  output logic                         dest_valid,
  input  logic                         dest_ready
);

  localparam int CNT_W = count_width(DOT_LEN);

  acc_state_e       state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             grp_ovf;

  logic [ACC_WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] count_inc;
  logic             accept;
  logic             closing;

  acc_adder #(
    .MUL_WIDTH (MUL_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .acc      (acc),
    .term     (product),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // Ready only in ACCUM and never while reset is held, so nothing is taken
  // on the reset edge.
  assign src_ready = (state == ACCUM) && !rst;

  // Accept and group-close decode for the current cycle.
  always_comb begin
    accept    = src_valid && src_ready;
    count_inc = count + CNT_W'(1);
    closing   = (count_inc == CNT_W'(DOT_LEN)) || src_last;
  end

  // Group FSM, running sum/count/overflow and registered result fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      grp_ovf      <= 1'b0;
      result       <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
      dest_valid   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (closing) begin
              // A closing term on the DOT_LEN-th slot still closes only once.
              result       <= add_sum;
              result_count <= count_inc;
              overflow     <= grp_ovf | add_ovf;
              dest_valid   <= 1'b1;
              state        <= HOLD;
            end else begin
              acc     <= add_sum;
              count   <= count_inc;
              grp_ovf <= grp_ovf | add_ovf;
            end
          end
        end
        HOLD: begin
          if (dest_ready) begin
            dest_valid <= 1'b0;
            acc        <= '0;
            count      <= '0;
            grp_ovf    <= 1'b0;
            state      <= ACCUM;
          end
        end
        default: begin
          state      <= ACCUM;
          dest_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (ACC_WIDTH=32 so overflow is reachable).
// The driver feeds terms and pushes each closed group's expected result, computed
// by a group-level arithmetic model, into a queue; a monitor pops and compares
// whenever a result is handed off, and checks results stay stable under backpressure.

module tb_product_accumulator;

  localparam int MW = 16;
  localparam int DL = 4;
  localparam int AW = 32;
  localparam int CW = $clog2(DL + 1);
  localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic [2*MW-1:0] product;
  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic [AW-1:0] result;
  logic [CW-1:0] result_count;
  logic          overflow;
  logic          dest_valid;
  logic          dest_ready;

  product_accumulator #(
    .MUL_WIDTH (MW),
    .DOT_LEN   (DL),
    .ACC_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .product      (product),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .result       (result),
    .result_count (result_count),
    .overflow     (overflow),
    .dest_valid   (dest_valid),
    .dest_ready   (dest_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    int     count;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint grp[$];
  int     n_vec = 0;
  int     n_bad = 0;
  bit     dr_hold = 1'b0;
  bit     dr_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Group result from plain integer arithmetic: add each term to the running
  // value; leaving the AW-bit signed range marks overflow and wraps or clamps.
  function automatic exp_t model_group(input longint terms[$]);
    exp_t   e;
    longint r;
    r     = 0;
    e.ovf = 1'b0;
    foreach (terms[i]) begin
      r = r + terms[i];
      if (r > AMAX || r < AMIN) begin
        e.ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
        r = (r > AMAX) ? AMAX : AMIN;
`else
        begin
          logic signed [AW-1:0] w;
          w = r[AW-1:0];
          r = longint'(w);
        end
`endif
      end
    end
    e.sum   = r;
    e.count = terms.size();
    return e;
  endfunction

  task automatic send(input longint t, input bit last, output int waited);
    logic [2*MW-1:0] p;
    bit ok;
    p      = t[2*MW-1:0];
    waited = 0;
    ok     = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      src_valid = 1'b1;
      product   = p;
      src_last  = last;
      #1;
      if (src_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      check("send_timeout", 64'(ok), 64'd1);
    end else begin
      grp.push_back(t);
      if (grp.size() == DL || last) begin
        exp_q.push_back(model_group(grp));
        grp.delete();
        @(posedge clk);
        #1;
        check("dest_valid_latency", 64'(dest_valid), 64'd1);
      end
    end
  endtask

  task automatic send1(input longint t, input bit last);
    int w;
    send(t, last, w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      src_valid = 1'b0;
      src_last  = 1'b0;
      product   = $urandom;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer-side ready: always, never, or random.
  initial begin
    dest_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (dr_hold)      dest_ready = 1'b0;
      else if (dr_rand) dest_ready = 1'($urandom_range(0, 1));
      else              dest_ready = 1'b1;
    end
  end

  // Monitor: compare on each result handoff; check stability while held.
  initial begin
    bit            held;
    logic [AW-1:0] h_res;
    logic [CW-1:0] h_cnt;
    logic          h_ovf;
    exp_t          e;
    logic [AW-1:0] es;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else if (dest_valid) begin
        if (held) begin
          check("hold_result", 64'(result), 64'(h_res));
          check("hold_count", 64'(result_count), 64'(h_cnt));
          check("hold_overflow", 64'(overflow), 64'(h_ovf));
        end
        if (dest_ready) begin
          check("result_pending", 64'(exp_q.size()), 64'd1);
          if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            es = e.sum[AW-1:0];
            check("result", 64'(result), 64'(es));
            check("result_count", 64'(result_count), 64'(e.count));
            check("overflow", 64'(overflow), 64'(e.ovf));
          end
          held = 1'b0;
        end else begin
          held  = 1'b1;
          h_res = result;
          h_cnt = result_count;
          h_ovf = overflow;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    rst       = 1'b1;
    src_valid = 1'b0;
    src_last  = 1'b0;
    product   = '0;
    repeat (2) @(negedge clk);
    #1 check("src_ready_in_reset", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_dest_valid", 64'(dest_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_count", 64'(result_count), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_src_ready", 64'(src_ready), 64'd1);

    // Full group, back-to-back.
    send1(6, 0); send1(-2, 0); send1(10, 0); send1(1, 0);
    // Early last, then a fresh group starting from zero.
    send1(7, 0); send1(8, 1);
    send1(20, 1);
    // src_last on the DOT_LEN-th term closes once; next term starts a new group.
    send1(1, 0); send1(2, 0); send1(3, 0); send1(4, 1);
    send1(5, 1);
    drain();

    // Backpressure: result held, src_ready low, new term accepted after handoff.
    idle(1);
    dr_hold = 1'b1;
    send1(1, 0); send1(1, 0); send1(1, 0); send1(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src_valid = 1'b1;
      product   = 32'd9;
      src_last  = 1'b0;
      #1 check("src_ready_in_hold", 64'(src_ready), 64'd0);
    end
    dr_hold = 1'b0;
    send(9, 1, w);
    check("accept_after_handshake", 64'(w), 64'd1);
    drain();

    // Overflow, positive and negative.
    send1(longint'(32'h4000_0000), 0); send1(longint'(32'h4000_0000), 1);
    send1(-longint'(32'h4000_0000), 0); send1(-longint'(32'h4000_0000), 0);
    send1(-longint'(32'h4000_0000), 1);
    drain();

    // Reset mid-group discards the partial sum.
    send1(5, 0); send1(5, 0);
    @(negedge clk);
    rst       = 1'b1;
    src_valid = 1'b0;
    src_last  = 1'b0;
    grp.delete();
    #1 check("src_ready_in_reset2", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset2_dest_valid", 64'(dest_valid), 64'd0);
    check("reset2_src_ready", 64'(src_ready), 64'd1);
    send1(3, 1);
    drain();

    // Randomized terms, gaps, early lasts and consumer backpressure.
    dr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      longint t;
      logic signed [2*MW-1:0] s;
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 1) == 0) begin
        t = longint'($urandom_range(0, 200)) - 100;
      end else begin
        s = $urandom;
        t = longint'(s);
      end
      send1(t, $urandom_range(0, 3) == 0);
    end
    send1(1, 1);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
